// File: rtl/id_decode_pipe_if.sv
// ID-stage bus: instruction, writeback and hazard inputs plus the registered ID/EXE outputs.
// slave = decode stage side, master = upstream/downstream driver side.
interface id_decode_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int PC_W     = 32
);
  localparam int REG_AW = $clog2(NUM_REGS);

  logic              instr_valid;
  logic [31:0]       instruction;
  logic [PC_W-1:0]   pc_in;
  logic [3:0]        status;
  logic              wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic [REG_AW-1:0] exe_dest, mem_dest;
  logic              exe_wb_en, mem_wb_en, exe_mem_read;
  logic              freeze, flush;
  logic              stall;
  logic              id_valid, id_wb_en, id_mem_read, id_mem_write, id_s, id_b, id_imm;
  logic [3:0]        id_exe_cmd;
  logic [DATA_W-1:0] id_val_rn, id_val_rm;
  logic [11:0]       id_shift_operand;
  logic [23:0]       id_imm24;
  logic [REG_AW-1:0] id_dest, id_src1, id_src2;
  logic [PC_W-1:0]   id_pc;

  modport slave (
    input  instr_valid, instruction, pc_in, status, wb_en, wb_dest, wb_value,
           exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_read, freeze, flush,
    output stall, id_valid, id_wb_en, id_mem_read, id_mem_write, id_s, id_b, id_imm,
           id_exe_cmd, id_val_rn, id_val_rm, id_shift_operand, id_imm24,
           id_dest, id_src1, id_src2, id_pc
  );

  modport master (
    output instr_valid, instruction, pc_in, status, wb_en, wb_dest, wb_value,
           exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_read, freeze, flush,
    input  stall, id_valid, id_wb_en, id_mem_read, id_mem_write, id_s, id_b, id_imm,
           id_exe_cmd, id_val_rn, id_val_rm, id_shift_operand, id_imm24,
           id_dest, id_src1, id_src2, id_pc
  );
endinterface

// File: rtl/id_decode_pipe.sv
// Registered decode stage: decode, 2R/1W register file, condition check, RAW hazard stall, ID/EXE register.
// Define FORWARDING_EN to restrict hazards to load-use against EXE.
module id_decode_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int PC_W     = 32
) (
  input logic            clk,
  input logic            rst,
  id_decode_pipe_if.slave bus
);
  localparam int REG_AW = $clog2(NUM_REGS);

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_ADD = 4'h4,
                         OP_ADC = 4'h5, OP_SBC = 4'h6, OP_TST = 4'h8, OP_CMP = 4'hA,
                         OP_ORR = 4'hC, OP_MOV = 4'hD, OP_MVN = 4'hF;

  typedef struct packed {
    logic              valid, wb_en, mem_read, mem_write, s, b, imm;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] val_rn, val_rm;
    logic [11:0]       shift;
    logic [23:0]       imm24;
    logic [REG_AW-1:0] dest, src1, src2;
    logic [PC_W-1:0]   pc;
  } idex_t;

  idex_t idex_q, idex_d, dec;

  logic [3:0]        cond, op;
  logic [1:0]        mode;
  logic              i_bit, s_bit, is_str, src1_used, src2_used, cond_ok, hazard;
  logic [REG_AW-1:0] rn, rd, rm, src2;
  logic [DATA_W-1:0] val_rn, val_rm;
  logic [3:0]        ctl_cmd;
  logic              ctl_wb, ctl_mr, ctl_mw, ctl_s, ctl_b, ctl_imm;
  logic [NUM_REGS-1:0][DATA_W-1:0] rf_q;

  assign cond  = bus.instruction[31:28];
  assign mode  = bus.instruction[27:26];
  assign i_bit = bus.instruction[25];
  assign op    = bus.instruction[24:21];
  assign s_bit = bus.instruction[20];
  assign rn    = bus.instruction[16 +: REG_AW];
  assign rd    = bus.instruction[12 +: REG_AW];
  assign rm    = bus.instruction[0 +: REG_AW];

  assign is_str    = (mode == 2'b01) && !s_bit;
  assign src2      = is_str ? rd : rm;
  assign src1_used = !((mode == 2'b10) || ((mode == 2'b00) && ((op == OP_MOV) || (op == OP_MVN))));
  assign src2_used = ((mode == 2'b00) && !i_bit) || is_str;

  // Writes land at the edge; same-cycle readers see wb_value directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rf_q <= '0;
    else if (bus.wb_en) rf_q[bus.wb_dest] <= bus.wb_value;
  end

  assign val_rn = (bus.wb_en && (bus.wb_dest == rn))   ? bus.wb_value : rf_q[rn];
  assign val_rm = (bus.wb_en && (bus.wb_dest == src2)) ? bus.wb_value : rf_q[src2];

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = bus.status[2];
      4'h1: cond_ok = !bus.status[2];
      4'h2: cond_ok = bus.status[1];
      4'h3: cond_ok = !bus.status[1];
      4'h4: cond_ok = bus.status[3];
      4'h5: cond_ok = !bus.status[3];
      4'h6: cond_ok = bus.status[0];
      4'h7: cond_ok = !bus.status[0];
      4'h8: cond_ok = bus.status[1] && !bus.status[2];
      4'h9: cond_ok = !bus.status[1] || bus.status[2];
      4'hA: cond_ok = (bus.status[3] == bus.status[0]);
      4'hB: cond_ok = (bus.status[3] != bus.status[0]);
      4'hC: cond_ok = !bus.status[2] && (bus.status[3] == bus.status[0]);
      4'hD: cond_ok = bus.status[2] || (bus.status[3] != bus.status[0]);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    ctl_cmd = 4'b0000;
    ctl_wb  = 1'b0;
    ctl_mr  = 1'b0;
    ctl_mw  = 1'b0;
    ctl_s   = 1'b0;
    ctl_b   = 1'b0;
    ctl_imm = 1'b0;
    case (mode)
      2'b00: begin
        ctl_imm = i_bit;
        ctl_s   = s_bit;
        ctl_wb  = 1'b1;
        case (op)
          OP_MOV: ctl_cmd = 4'b0001;
          OP_MVN: ctl_cmd = 4'b1001;
          OP_ADD: ctl_cmd = 4'b0010;
          OP_ADC: ctl_cmd = 4'b0011;
          OP_SUB: ctl_cmd = 4'b0100;
          OP_SBC: ctl_cmd = 4'b0101;
          OP_AND: ctl_cmd = 4'b0110;
          OP_ORR: ctl_cmd = 4'b0111;
          OP_EOR: ctl_cmd = 4'b1000;
          OP_TST: begin ctl_cmd = 4'b0110; ctl_wb = 1'b0; ctl_s = 1'b1; end
          OP_CMP: begin ctl_cmd = 4'b0100; ctl_wb = 1'b0; ctl_s = 1'b1; end
          default: begin ctl_imm = 1'b0; ctl_s = 1'b0; ctl_wb = 1'b0; end
        endcase
      end
      2'b01: begin
        ctl_cmd = 4'b0010;
        ctl_imm = i_bit;
        ctl_wb  = s_bit;
        ctl_mr  = s_bit;
        ctl_mw  = !s_bit;
      end
      2'b10: ctl_b = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.wb_en     = ctl_wb & cond_ok;
    dec.mem_read  = ctl_mr & cond_ok;
    dec.mem_write = ctl_mw & cond_ok;
    dec.s         = ctl_s  & cond_ok;
    dec.b         = ctl_b  & cond_ok;
    dec.imm       = ctl_imm;
    dec.exe_cmd   = ctl_cmd;
    dec.val_rn    = val_rn;
    dec.val_rm    = val_rm;
    dec.shift     = bus.instruction[11:0];
    dec.imm24     = bus.instruction[23:0];
    dec.dest      = rd;
    dec.src1      = rn;
    dec.src2      = src2;
    dec.pc        = bus.pc_in;
  end

`ifdef FORWARDING_EN
  // ALU results are forwarded; only a load in EXE cannot be.
  logic unused_mem_hazard;
  assign unused_mem_hazard = &{1'b0, bus.mem_dest, bus.mem_wb_en};
  assign hazard = bus.exe_mem_read && bus.exe_wb_en &&
                  ((src1_used && (bus.exe_dest == rn)) || (src2_used && (bus.exe_dest == src2)));
`else
  logic unused_load_flag;
  assign unused_load_flag = &{1'b0, bus.exe_mem_read};
  assign hazard = (bus.exe_wb_en && ((src1_used && (bus.exe_dest == rn)) ||
                                     (src2_used && (bus.exe_dest == src2)))) ||
                  (bus.mem_wb_en && ((src1_used && (bus.mem_dest == rn)) ||
                                     (src2_used && (bus.mem_dest == src2))));
`endif

  assign bus.stall = bus.instr_valid & hazard;

  always_comb begin
    idex_d = idex_q;
    if (bus.flush)                               idex_d = '0;
    else if (!bus.freeze) begin
      if (bus.stall || !bus.instr_valid)         idex_d = '0;
      else                                       idex_d = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign bus.id_valid         = idex_q.valid;
  assign bus.id_wb_en         = idex_q.wb_en;
  assign bus.id_mem_read      = idex_q.mem_read;
  assign bus.id_mem_write     = idex_q.mem_write;
  assign bus.id_s             = idex_q.s;
  assign bus.id_b             = idex_q.b;
  assign bus.id_imm           = idex_q.imm;
  assign bus.id_exe_cmd       = idex_q.exe_cmd;
  assign bus.id_val_rn        = idex_q.val_rn;
  assign bus.id_val_rm        = idex_q.val_rm;
  assign bus.id_shift_operand = idex_q.shift;
  assign bus.id_imm24         = idex_q.imm24;
  assign bus.id_dest          = idex_q.dest;
  assign bus.id_src1          = idex_q.src1;
  assign bus.id_src2          = idex_q.src2;
  assign bus.id_pc            = idex_q.pc;
endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: a behavioural model checked every cycle plus literal expectations.
module tb_id_decode_pipe;
  localparam int DATA_W = 32, NUM_REGS = 16, PC_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic run = 1'b0;
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  id_decode_pipe_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .PC_W(PC_W)) bus ();
  id_decode_pipe #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ALU command per data-processing opcode; -1 marks an opcode this stage does not support.
  int dp_tab [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

  logic [31:0] mregs [16];
  logic [10:0] m_ctrl;     // {valid,wb,mr,mw,s,b,imm,cmd}
  logic [31:0] m_rn, m_rm, m_pc;
  logic [47:0] m_fld;      // {shift,imm24,dest,src1,src2}

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] nzcv);
    bit n = nzcv[3], z = nzcv[2], cy = nzcv[1], v = nzcv[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_src2(input logic [31:0] ins);
    return (ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0];
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (bus.wb_en && bus.wb_dest == a) return bus.wb_value;
    return mregs[a];
  endfunction

  function automatic logic [10:0] m_decode(input logic [31:0] ins, input logic [3:0] st);
    logic [1:0] mode = ins[27:26];
    int op = int'(ins[24:21]);
    bit wb = 0, mr = 0, mw = 0, s = 0, b = 0, imm = 0;
    logic [3:0] cmd = 4'd0;
    if (mode == 2'b00 && dp_tab[op] >= 0) begin
      cmd = 4'(dp_tab[op]);
      imm = ins[25];
      wb  = !(op == 8 || op == 10);
      s   = ins[20] || op == 8 || op == 10;
    end else if (mode == 2'b01) begin
      cmd = 4'd2; imm = ins[25]; wb = ins[20]; mr = ins[20]; mw = !ins[20];
    end else if (mode == 2'b10) begin
      b = 1;
    end
    if (!m_cond(ins[31:28], st)) begin wb = 0; mr = 0; mw = 0; s = 0; b = 0; end
    return {1'b1, wb, mr, mw, s, b, imm, cmd};
  endfunction

  function automatic bit m_stall();
    logic [31:0] ins = bus.instruction;
    bit u1 = !(ins[27:26] == 2'b10 || (ins[27:26] == 2'b00 && (ins[24:21] == 4'hD || ins[24:21] == 4'hF)));
    bit u2 = (ins[27:26] == 2'b00 && !ins[25]) || (ins[27:26] == 2'b01 && !ins[20]);
    bit hit_e = (u1 && bus.exe_dest == ins[19:16]) || (u2 && bus.exe_dest == m_src2(ins));
    bit hit_m = (u1 && bus.mem_dest == ins[19:16]) || (u2 && bus.mem_dest == m_src2(ins));
`ifdef FORWARDING_EN
    return bus.instr_valid && bus.exe_mem_read && bus.exe_wb_en && hit_e;
`else
    return bus.instr_valid && ((bus.exe_wb_en && hit_e) || (bus.mem_wb_en && hit_m));
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctrl <= '0; m_rn <= '0; m_rm <= '0; m_pc <= '0; m_fld <= '0;
      for (int i = 0; i < 16; i++) mregs[i] <= '0;
    end else begin
      if (bus.flush || (!bus.freeze && (m_stall() || !bus.instr_valid))) begin
        m_ctrl <= '0; m_rn <= '0; m_rm <= '0; m_pc <= '0; m_fld <= '0;
      end else if (!bus.freeze) begin
        m_ctrl <= m_decode(bus.instruction, bus.status);
        m_rn   <= m_read(bus.instruction[19:16]);
        m_rm   <= m_read(m_src2(bus.instruction));
        m_pc   <= bus.pc_in;
        m_fld  <= {bus.instruction[11:0], bus.instruction[23:0], bus.instruction[15:12],
                   bus.instruction[19:16], m_src2(bus.instruction)};
      end
      if (bus.wb_en) mregs[bus.wb_dest] <= bus.wb_value;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("ctrl", {bus.id_valid, bus.id_wb_en, bus.id_mem_read, bus.id_mem_write, bus.id_s,
                   bus.id_b, bus.id_imm, bus.id_exe_cmd}, m_ctrl);
      chk("val_rn", bus.id_val_rn, m_rn);
      chk("val_rm", bus.id_val_rm, m_rm);
      chk("fields", {bus.id_shift_operand, bus.id_imm24, bus.id_dest, bus.id_src1, bus.id_src2}, m_fld);
      chk("pc", bus.id_pc, m_pc);
      chk("stall", bus.stall, m_stall());
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] dp(input logic [3:0] c, input logic i, input logic [3:0] op,
                                     input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] sh);
    return {c, 2'b00, i, op, s, rn, rd, sh};
  endfunction

  function automatic logic [31:0] mem(input logic [3:0] c, input logic i, input logic l,
                                      input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] off);
    return {c, 2'b01, i, 4'b0100, l, rn, rd, off};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instr_valid = 0; bus.instruction = '0; bus.pc_in = '0; bus.status = 4'b0000;
    bus.wb_en = 0; bus.wb_dest = '0; bus.wb_value = '0;
    bus.exe_dest = '0; bus.mem_dest = '0; bus.exe_wb_en = 0; bus.mem_wb_en = 0;
    bus.exe_mem_read = 0; bus.freeze = 0; bus.flush = 0;
  endtask

  localparam logic [3:0] AL = 4'hE, EQ = 4'h0, NV = 4'hF;
  logic [3:0] sts [7] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b1001, 4'b0110};
  logic [3:0] ops [8] = '{4'hF, 4'hC, 4'h1, 4'h0, 4'h5, 4'h6, 4'h8, 4'hD};

  initial begin
    rst = 1'b1;
    idle();
    #2;
    run = 1'b1;
    chk("rst_valid", bus.id_valid, 0);
    chk("rst_pc", bus.id_pc, 0);
    tick(); tick();
    rst = 1'b0;

    // write R3 then read it back through the pipe register
    bus.wb_en = 1; bus.wb_dest = 3; bus.wb_value = 32'hA5;
    tick();
    bus.wb_en = 0; bus.instr_valid = 1; bus.pc_in = 32'd100;
    bus.instruction = dp(AL, 0, 4'h4, 0, 4'd3, 4'd1, 12'h003);
    tick();
    chk("t1_rn", bus.id_val_rn, 32'hA5);
    chk("t1_rm", bus.id_val_rm, 32'hA5);
    chk("t1_cmd", bus.id_exe_cmd, 4'b0010);
    chk("t1_wb", bus.id_wb_en, 1);

    // write-through in the same cycle
    bus.wb_en = 1; bus.wb_dest = 2; bus.wb_value = 32'h55;
    bus.instruction = dp(AL, 0, 4'h4, 0, 4'd2, 4'd4, 12'h002); bus.pc_in = 32'd104;
    tick();
    bus.wb_en = 0;
    chk("t2_rn", bus.id_val_rn, 32'h55);
    chk("t2_rm", bus.id_val_rm, 32'h55);

    // RAW against EXE
    bus.exe_wb_en = 1; bus.exe_dest = 5;
    bus.instruction = dp(AL, 1, 4'h2, 0, 4'd5, 4'd6, 12'h001); bus.pc_in = 32'd108;
    #1;
`ifdef FORWARDING_EN
    chk("t3_stall", bus.stall, 0);
    tick();
    chk("t3_valid", bus.id_valid, 1);
`else
    chk("t3_stall", bus.stall, 1);
    tick();
    chk("t3_valid", bus.id_valid, 0);
`endif
    bus.instruction = dp(AL, 1, 4'hD, 0, 4'd5, 4'd6, 12'h001);
    #1;
    chk("t3_mov_stall", bus.stall, 0);
    tick();
`ifdef FORWARDING_EN
    bus.exe_mem_read = 1;
    bus.instruction = dp(AL, 1, 4'h2, 0, 4'd5, 4'd6, 12'h001);
    #1;
    chk("t4_loaduse", bus.stall, 1);
    tick();
    chk("t4_bubble", bus.id_valid, 0);
    bus.exe_mem_read = 0; bus.exe_wb_en = 0;
    #1;
    chk("t4_release", bus.stall, 0);
    tick();
`endif
    bus.exe_wb_en = 0; bus.exe_mem_read = 0;

    // store source is Rd; MEM-stage hazard
    bus.mem_wb_en = 1; bus.mem_dest = 7;
    bus.instruction = mem(AL, 0, 0, 4'd1, 4'd7, 12'h000); bus.pc_in = 32'd112;
    tick();
    bus.mem_wb_en = 0;
    tick();
    chk("str_mw", bus.id_mem_write, 1);
    chk("str_src2", bus.id_src2, 7);
    bus.instruction = mem(AL, 1, 1, 4'd2, 4'd8, 12'h004); tick();
    chk("ldr_mr", {bus.id_wb_en, bus.id_mem_read, bus.id_exe_cmd}, 6'b11_0010);
    bus.instruction = {AL, 2'b10, 1'b1, 1'b0, 24'h000010}; tick();
    chk("br_b", {bus.id_b, bus.id_wb_en}, 2'b10);
    bus.instruction = dp(AL, 0, 4'hA, 0, 4'd1, 4'd0, 12'h002); tick();
    chk("cmp", {bus.id_s, bus.id_wb_en, bus.id_exe_cmd}, 6'b10_0100);
    bus.instruction = dp(AL, 0, 4'h3, 1, 4'd1, 4'd2, 12'h003); tick();
    chk("undef", {bus.id_valid, bus.id_wb_en, bus.id_s, bus.id_exe_cmd}, 7'b100_0000);
    for (int k = 0; k < 8; k++) begin
      bus.instruction = dp(AL, k[0], ops[k], k[1], 4'(k), 4'(k + 1), 12'(k * 3));
      tick();
    end

    // condition field
    bus.status = 4'b0000;
    bus.instruction = dp(EQ, 0, 4'h4, 0, 4'd1, 4'd2, 12'h003); tick();
    chk("eq_false", {bus.id_valid, bus.id_wb_en}, 2'b10);
    bus.status = 4'b0100; tick();
    chk("eq_true", {bus.id_valid, bus.id_wb_en}, 2'b11);
    bus.instruction = dp(NV, 0, 4'h4, 1, 4'd1, 4'd2, 12'h003); tick();
    chk("nv", {bus.id_valid, bus.id_wb_en, bus.id_s}, 3'b100);
    for (int c = 0; c < 16; c++)
      for (int s = 0; s < 7; s++) begin
        bus.status = sts[s];
        bus.instruction = dp(4'(c), 0, 4'h4, 1, 4'd1, 4'd2, 12'h003);
        tick();
      end

    // freeze hold, flush over freeze, flush with stall
    bus.instruction = dp(AL, 0, 4'h4, 0, 4'd3, 4'd1, 12'h003); bus.pc_in = 32'd200;
    tick();
    bus.freeze = 1; bus.pc_in = 32'd204;
    bus.instruction = dp(AL, 0, 4'h2, 0, 4'd4, 4'd9, 12'h004);
    repeat (3) begin
      tick();
      chk("frz_pc", bus.id_pc, 32'd200);
    end
    bus.flush = 1; tick();
    chk("flush_frz", bus.id_valid, 0);
    bus.flush = 0; bus.freeze = 0; tick();
    bus.flush = 1; bus.exe_wb_en = 1; bus.exe_mem_read = 1; bus.exe_dest = 4;
    #1;
    chk("flush_stall", bus.stall, 1);
    tick();
    chk("flush_bub", bus.id_valid, 0);
    bus.flush = 0; bus.exe_wb_en = 0; bus.exe_mem_read = 0;

    // reset while stalled with a valid entry held
    bus.pc_in = 32'd300; tick();
    bus.exe_wb_en = 1; bus.exe_mem_read = 1; bus.exe_dest = 4;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid", {bus.id_valid, bus.id_pc, bus.id_val_rn}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.exe_wb_en = 0; bus.exe_mem_read = 0;
    bus.instruction = dp(AL, 0, 4'h4, 0, 4'd3, 4'd1, 12'h003);
    tick();
    chk("rst_rf", bus.id_val_rn, 0);
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
